// File: rtl/hvsync_gen_pkg.sv
// Shared video-timing definitions for the display pipeline.
// Holds the raster counter widths, the default 640x480 timing constants,
// the per-frame object update line and a small range-decode helper.
package hvsync_gen_pkg;

    localparam int unsigned X_WIDTH = 10;
    localparam int unsigned Y_WIDTH = 9;

    typedef logic [X_WIDTH-1:0] x_t;
    typedef logic [Y_WIDTH-1:0] y_t;

    localparam int unsigned DEF_H_ACTIVE     = 640;
    localparam int unsigned DEF_H_SYNC_START = 656;
    localparam int unsigned DEF_H_SYNC_END   = 752;
    localparam int unsigned DEF_H_TOTAL      = 800;
    localparam int unsigned DEF_V_ACTIVE     = 480;
    localparam int unsigned DEF_V_SYNC_START = 490;
    localparam int unsigned DEF_V_SYNC_END   = 492;
    localparam int unsigned DEF_V_TOTAL      = 512;

    // Object modules latch their new positions while CounterY is on this line.
    localparam int unsigned UPDATE_LINE = 500;

    // True when lo <= v < hi.
    function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/hvsync_gen_wrap_counter.sv
// Enabled modulo counter used for the raster X and Y axes.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (reset forces 0)
//   en          - advance by one (wrapping to 0 after MODULUS-1)
//   count       - registered count
//   count_next  - value count takes at the next edge (reset included)
//   wrap        - high while en is set and count is at MODULUS-1
module hvsync_gen_wrap_counter #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned MODULUS = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    logic at_max;

    assign at_max = (count == WIDTH'(MODULUS - 1));
    assign wrap   = en && at_max;

    always_comb begin
        count_next = count;
        if (reset) begin
            count_next = '0;
        end else if (en) begin
            count_next = at_max ? '0 : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count <= count_next;
    end

endmodule

// File: rtl/hvsync_gen.sv
// Video timing generator: raster counters, sync levels, display qualifier,
// line/frame start pulses and a frame counter. Advances on pix_en ticks.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   pix_en              - pixel tick
//   CounterX, CounterY  - current pixel column / line
//   inDisplayArea       - inside the visible window
//   vga_h_sync/v_sync   - sync levels (asserted level set by *_POL)
//   line_start          - one-cycle pulse when CounterX first shows 0 after a wrap
//   frame_start         - one-cycle pulse when (0,0) first shows after a frame wrap
//   frame_count         - completed frames modulo 256
module hvsync_gen
    import hvsync_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter bit          HSYNC_POL    = 1'b0,
    parameter bit          VSYNC_POL    = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_en,
    output logic [9:0]   CounterX,
    output logic [8:0]   CounterY,
    output logic         inDisplayArea,
    output logic         vga_h_sync,
    output logic         vga_v_sync,
    output logic         line_start,
    output logic         frame_start,
    output logic [7:0]   frame_count
);

    if (!((H_SYNC_START < H_SYNC_END) && (H_SYNC_END <= H_TOTAL) && (H_TOTAL <= 1024)))
    begin : gen_h_check
        $error("hvsync_gen: horizontal timing out of range");
    end
    if (!((V_SYNC_START < V_SYNC_END) && (V_SYNC_END <= V_TOTAL) && (V_TOTAL <= 512)))
    begin : gen_v_check
        $error("hvsync_gen: vertical timing out of range");
    end
    if (!((H_ACTIVE <= H_SYNC_START) && (V_ACTIVE <= V_SYNC_START))) begin : gen_a_check
        $error("hvsync_gen: active area overlaps sync");
    end

    x_t   x_next;
    y_t   y_next;
    logic x_wrap;
    logic y_wrap;

    hvsync_gen_wrap_counter #(
        .WIDTH   (X_WIDTH),
        .MODULUS (H_TOTAL)
    ) u_x_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (pix_en),
        .count      (CounterX),
        .count_next (x_next),
        .wrap       (x_wrap)
    );

    // Y only moves when X wraps, so its wrap-out marks the end of a frame.
    hvsync_gen_wrap_counter #(
        .WIDTH   (Y_WIDTH),
        .MODULUS (V_TOTAL)
    ) u_y_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (x_wrap),
        .count      (CounterY),
        .count_next (y_next),
        .wrap       (y_wrap)
    );

    // Levels decode the next-state counters so they land in the same cycle
    // as the counter values they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= 8'd0;
            inDisplayArea <= 1'b1;
            vga_h_sync    <= !HSYNC_POL;
            vga_v_sync    <= !VSYNC_POL;
        end else begin
            line_start  <= x_wrap;
            frame_start <= y_wrap;
            if (y_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
            inDisplayArea <= in_range(32'(x_next), 0, H_ACTIVE) &&
                             in_range(32'(y_next), 0, V_ACTIVE);
            vga_h_sync    <= in_range(32'(x_next), H_SYNC_START, H_SYNC_END) ?
                             HSYNC_POL : !HSYNC_POL;
            vga_v_sync    <= in_range(32'(y_next), V_SYNC_START, V_SYNC_END) ?
                             VSYNC_POL : !VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_hvsync_gen.sv
// Self-checking bench for hvsync_gen: a default-timing instance (A) and a
// shrunken-timing instance with active-high hsync (B) so frame wraps and
// frame_count rollover fit in a short run.
module tb_hvsync_gen;

    typedef struct {
        int ha, hss, hse, ht, va, vss, vse, vt;
        bit hp, vp;
    } timing_t;

    typedef struct {
        int x, y, fc;
        bit ls, fs;
    } model_t;

    typedef struct {
        int x, y, fc;
        bit disp, hs, vs, ls, fs;
    } obs_t;

    typedef struct {
        bit rst, en;
        int x, y;
        bit ls, fs;
        int fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_a, pix_en_a, reset_b, pix_en_b;
    logic [9:0] cx_a, cx_b;
    logic [8:0] cy_a, cy_b;
    logic       disp_a, disp_b, hs_a, hs_b, vs_a, vs_b, ls_a, ls_b, fs_a, fs_b;
    logic [7:0] fc_a, fc_b;

    int tests = 0;
    int failed = 0;

    timing_t ta, tb;
    model_t  ma, mb;
    obs_t    q_a[$];
    obs_t    q_b[$];
    obs_t    oa, ob;

    always #5 clk = ~clk;

    hvsync_gen dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .pix_en        (pix_en_a),
        .CounterX      (cx_a),
        .CounterY      (cy_a),
        .inDisplayArea (disp_a),
        .vga_h_sync    (hs_a),
        .vga_v_sync    (vs_a),
        .line_start    (ls_a),
        .frame_start   (fs_a),
        .frame_count   (fc_a)
    );

    hvsync_gen #(
        .H_ACTIVE     (10),
        .H_SYNC_START (12),
        .H_SYNC_END   (15),
        .H_TOTAL      (20),
        .V_ACTIVE     (6),
        .V_SYNC_START (8),
        .V_SYNC_END   (9),
        .V_TOTAL      (12),
        .HSYNC_POL    (1'b1),
        .VSYNC_POL    (1'b0)
    ) dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .pix_en        (pix_en_b),
        .CounterX      (cx_b),
        .CounterY      (cy_b),
        .inDisplayArea (disp_b),
        .vga_h_sync    (hs_b),
        .vga_v_sync    (vs_b),
        .line_start    (ls_b),
        .frame_start   (fs_b),
        .frame_count   (fc_b)
    );

    function automatic model_t model_step(input model_t m, input bit rst, input bit en,
                                          input timing_t t);
        model_t n;
        n = m;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (rst) begin
            n.x = 0;
            n.y = 0;
            n.fc = 0;
        end else if (en) begin
            if (m.x == t.ht - 1) begin
                n.x = 0;
                n.ls = 1'b1;
                if (m.y == t.vt - 1) begin
                    n.y = 0;
                    n.fs = 1'b1;
                    n.fc = (m.fc + 1) % 256;
                end else begin
                    n.y = m.y + 1;
                end
            end else begin
                n.x = m.x + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t expect_of(input model_t m, input timing_t t);
        obs_t e;
        e.x = m.x;
        e.y = m.y;
        e.fc = m.fc;
        e.ls = m.ls;
        e.fs = m.fs;
        e.disp = (m.x < t.ha) && (m.y < t.va);
        e.hs = (m.x >= t.hss && m.x < t.hse) ? t.hp : !t.hp;
        e.vs = (m.y >= t.vss && m.y < t.vse) ? t.vp : !t.vp;
        return e;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got x=%0d y=%0d disp=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected x=%0d y=%0d disp=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                     name, got.x, got.y, got.disp, got.hs, got.vs, got.ls, got.fs, got.fc,
                     exp.x, exp.y, exp.disp, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive one clock of stimulus on both instances, push the model's
    // expectation, then pop and compare after the edge.
    task automatic cycle(input bit ra, input bit ea, input bit rb, input bit eb);
        obs_t ea_exp, eb_exp;
        reset_a = ra;
        pix_en_a = ea;
        reset_b = rb;
        pix_en_b = eb;
        ma = model_step(ma, ra, ea, ta);
        mb = model_step(mb, rb, eb, tb);
        q_a.push_back(expect_of(ma, ta));
        q_b.push_back(expect_of(mb, tb));
        @(posedge clk);
        #1;
        oa.x = int'(cx_a); oa.y = int'(cy_a); oa.fc = int'(fc_a);
        oa.disp = disp_a; oa.hs = hs_a; oa.vs = vs_a; oa.ls = ls_a; oa.fs = fs_a;
        ob.x = int'(cx_b); ob.y = int'(cy_b); ob.fc = int'(fc_b);
        ob.disp = disp_b; ob.hs = hs_b; ob.vs = vs_b; ob.ls = ls_b; ob.fs = fs_b;
        ea_exp = q_a.pop_front();
        eb_exp = q_b.pop_front();
        check_obs("sb_a", oa, ea_exp);
        check_obs("sb_b", ob, eb_exp);
    endtask

    initial begin
        vec_t vecs[8];
        int hs_low, disp_hi, ls_cnt, fs_cnt, vs_low, hs_hi, guard;
        bit en;

        ta = '{640, 656, 752, 800, 480, 490, 492, 512, 1'b0, 1'b0};
        tb = '{10, 12, 15, 20, 6, 8, 9, 12, 1'b1, 1'b0};
        ma = '{0, 0, 0, 1'b0, 1'b0};
        mb = '{0, 0, 0, 1'b0, 1'b0};

        // Reset, pix_en 1,0,0,1 pattern, reset beats pix_en.
        vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 0};

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rst, vecs[i].en, 1'b1, 1'b0);
            check_int($sformatf("vec%0d_x", i), oa.x, vecs[i].x);
            check_int($sformatf("vec%0d_y", i), oa.y, vecs[i].y);
            check_int($sformatf("vec%0d_pulses", i), {oa.ls, oa.fs},
                      {vecs[i].ls, vecs[i].fs});
            check_int($sformatf("vec%0d_fc", i), oa.fc, vecs[i].fc);
        end
        check_int("reset_levels", {oa.hs, oa.vs}, 2'b11);

        // Line 0 on A: observe x=0 (reset) and 799 ticks, then one wrap tick.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        hs_low = 0; disp_hi = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (oa.y == 0 && !oa.hs) hs_low++;
            if (oa.y == 0 && oa.disp) disp_hi++;
            ls_cnt += int'(oa.ls);
            fs_cnt += int'(oa.fs);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        ls_cnt += int'(oa.ls);
        fs_cnt += int'(oa.fs);
        check_int("line0_hsync_low", hs_low, 96);
        check_int("line0_display", disp_hi, 640);
        check_int("line_pulses", ls_cnt, 1);
        check_int("frame_pulses", fs_cnt, 0);
        check_int("wrap_x", oa.x, 0);
        check_int("wrap_y", oa.y, 1);

        // Idle after a wrap: the pulse must not repeat.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_int("idle_no_pulse", int'(oa.ls), 0);
        check_int("idle_hold_x", oa.x, 0);

        // Mid-frame reset at x=300 of line 1.
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_int("pre_reset_x", oa.x, 300);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_int("midreset_xy", oa.x + oa.y, 0);
        check_int("midreset_pulses", {oa.ls, oa.fs}, 0);
        check_int("midreset_syncs", {oa.hs, oa.vs, oa.disp}, 3'b111);

        // B: first frame with random pix_en; count distinct states per level.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        vs_low = int'(!ob.vs);
        hs_hi = int'(ob.hs && ob.y == 0);
        guard = 0;
        do begin
            en = 1'($urandom_range(0, 1));
            cycle(1'b1, 1'b0, 1'b0, en);
            guard++;
            if (en && !ob.fs) begin
                vs_low += int'(!ob.vs);
                hs_hi += int'(ob.hs && ob.y == 0);
            end
        end while (!ob.fs && guard < 3000);
        check_int("frame1_reached", int'(ob.fs), 1);
        check_int("frame1_both_pulses", int'(ob.ls), 1);
        check_int("frame1_vsync_low", vs_low, 20);
        check_int("frame1_hsync_high", hs_hi, 3);
        check_int("frame1_count", ob.fc, 1);

        // Remaining frames up to 256: frame_count rolls over to 0.
        for (int f = 2; f <= 256; f++) begin
            for (int i = 0; i < 240; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
            check_int($sformatf("frame%0d_count", f), ob.fc, f % 256);
            check_int($sformatf("frame%0d_pulses", f), {ob.ls, ob.fs}, 2'b11);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
